// File: rtl/l1ca_acq_ctrl.sv
// rtl/l1ca_acq_ctrl.sv - GPS L1 C/A acquisition search controller
//
// Purpose: steps a shared acquisition correlator through every
// (Doppler bin, code phase) cell for one SV. It keeps the cell with the
// largest |I|+|Q| and reports that cell and a threshold detection flag.
//
// Ports:
//   clk, nrst      clock, asynchronous active-low reset
//   start_i        begin a search (accepted only in IDLE, abort_i low)
//   abort_i        leave any active state and return to IDLE
//   sv_i           SV number, latched on an accepted start
//   thresh_i       detection threshold, latched on an accepted start
//   busy_o         search in progress (ISSUE/WAIT/EVAL/DONE)
//   done_o         one-cycle pulse at sweep completion
//   found_o        best magnitude >= latched threshold (valid from done_o)
//   best_chip_o    code phase of the peak cell
//   best_dopp_o    Doppler bin of the peak cell
//   best_mag_o     peak |I|+|Q|
//   corr_start_o   one-cycle correlator request
//   corr_sv_o      latched SV presented to the correlator
//   corr_chip_o    code phase being correlated
//   corr_dopp_o    Doppler bin being correlated
//   corr_done_i    correlator result strobe (single cycle)
//   corr_i_i       in-phase accumulation (signed)
//   corr_q_i       quadrature accumulation (signed)

module l1ca_acq_ctrl #(
  parameter int  NUM_DOPP = 21,
  parameter int  ACC_W    = 16,
  localparam int DW       = (NUM_DOPP > 1) ? $clog2(NUM_DOPP) : 1,
  localparam int MAG_W    = ACC_W + 1,
  localparam int SV_W     = 5,
  localparam int CHIP_W   = 10
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [SV_W-1:0]         sv_i,
  input  logic [MAG_W-1:0]        thresh_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    found_o,
  output logic [CHIP_W-1:0]       best_chip_o,
  output logic [DW-1:0]           best_dopp_o,
  output logic [MAG_W-1:0]        best_mag_o,
  output logic                    corr_start_o,
  output logic [SV_W-1:0]         corr_sv_o,
  output logic [CHIP_W-1:0]       corr_chip_o,
  output logic [DW-1:0]           corr_dopp_o,
  input  logic                    corr_done_i,
  input  logic signed [ACC_W-1:0] corr_i_i,
  input  logic signed [ACC_W-1:0] corr_q_i
);

  localparam logic [CHIP_W-1:0] LAST_CHIP = CHIP_W'(1022);
  localparam logic [DW-1:0]     LAST_DOPP = DW'(NUM_DOPP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EVAL,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [SV_W-1:0]         sv_q;
  logic [MAG_W-1:0]        thr_q;
  logic [CHIP_W-1:0]       chip_q;
  logic [DW-1:0]           dopp_q;
  logic signed [ACC_W-1:0] i_q;
  logic signed [ACC_W-1:0] q_q;
  logic [MAG_W-1:0]        best_mag_q;
  logic [CHIP_W-1:0]       best_chip_q;
  logic [DW-1:0]           best_dopp_q;
  logic                    found_q;

  logic                    accept;
  logic [MAG_W-1:0]        abs_i;
  logic [MAG_W-1:0]        abs_q;
  logic [MAG_W-1:0]        mag;
  logic                    first_cell;
  logic                    upd;
  logic                    last_chip;
  logic                    last_cell;
  logic [MAG_W-1:0]        final_mag;

  assign accept = start_i && !abort_i;

  // Magnitude is formed one bit wider than the accumulators, so the
  // negation of the most negative value (-32768 -> 32768) cannot wrap and
  // the sum of two such values (65536) still fits.
  always_comb begin
    abs_i = i_q[ACC_W-1] ? (~{i_q[ACC_W-1], i_q} + MAG_W'(1)) : {1'b0, i_q};
    abs_q = q_q[ACC_W-1] ? (~{q_q[ACC_W-1], q_q} + MAG_W'(1)) : {1'b0, q_q};
    mag   = abs_i + abs_q;
  end

  // The first cell of a sweep always claims the best slot so that an
  // all-zero sweep reports cell (0,0) rather than stale coordinates.
  // Afterwards only a strictly larger magnitude replaces it, so the first
  // of several equal peaks is kept.
  assign first_cell = (chip_q == '0) && (dopp_q == '0);
  assign upd        = first_cell || (mag > best_mag_q);
  assign last_chip  = (chip_q == LAST_CHIP);
  assign last_cell  = last_chip && (dopp_q == LAST_DOPP);
  assign final_mag  = upd ? mag : best_mag_q;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort pre-empts every active state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = abort_i ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (abort_i)          state_nxt = S_IDLE;
        else if (corr_done_i) state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (abort_i)        state_nxt = S_IDLE;
        else if (last_cell) state_nxt = S_DONE;
        else                state_nxt = S_ISSUE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs; corr_start_o follows the state register so a
  // reset removes the request without waiting for a clock edge.
  always_comb begin
    busy_o       = 1'b0;
    done_o       = 1'b0;
    corr_start_o = 1'b0;
    unique case (state)
      S_IDLE:  ;
      S_ISSUE: begin
        busy_o       = 1'b1;
        corr_start_o = 1'b1;
      end
      S_WAIT:  busy_o = 1'b1;
      S_EVAL:  busy_o = 1'b1;
      S_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Search datapath: latched request, cell counters, I/Q capture, best cell
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sv_q        <= '0;
      thr_q       <= '0;
      chip_q      <= '0;
      dopp_q      <= '0;
      i_q         <= '0;
      q_q         <= '0;
      best_mag_q  <= '0;
      best_chip_q <= '0;
      best_dopp_q <= '0;
      found_q     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            sv_q       <= sv_i;
            thr_q      <= thresh_i;
            chip_q     <= '0;
            dopp_q     <= '0;
            best_mag_q <= '0;
          end
        end
        S_WAIT: begin
          if (corr_done_i && !abort_i) begin
            i_q <= corr_i_i;
            q_q <= corr_q_i;
          end
        end
        S_EVAL: begin
          if (!abort_i) begin
            if (upd) begin
              best_mag_q  <= mag;
              best_chip_q <= chip_q;
              best_dopp_q <= dopp_q;
            end
            // Code phase is the inner loop; the final cell leaves the
            // counters parked since DONE follows.
            if (!last_chip) begin
              chip_q <= chip_q + CHIP_W'(1);
            end else if (!last_cell) begin
              chip_q <= '0;
              dopp_q <= dopp_q + DW'(1);
            end
            // Registered on the way into DONE so it is already valid in
            // the done_o cycle.
            if (last_cell) begin
              found_q <= (final_mag >= thr_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign found_o     = found_q;
  assign best_chip_o = best_chip_q;
  assign best_dopp_o = best_dopp_q;
  assign best_mag_o  = best_mag_q;
  assign corr_sv_o   = sv_q;
  assign corr_chip_o = chip_q;
  assign corr_dopp_o = dopp_q;

endmodule

// File: tb/tb_l1ca_acq_ctrl.sv
// tb/tb_l1ca_acq_ctrl.sv - directed self-checking bench for l1ca_acq_ctrl

module tb_l1ca_acq_ctrl;

  localparam int ND    = 3;
  localparam int DW    = 2;
  localparam int MAG_W = 17;
  localparam int NCELL = ND * 1023;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic [4:0]        sv_i = '0;
  logic [MAG_W-1:0]  thresh_i = '0;
  logic              busy_o, done_o, found_o;
  logic [9:0]        best_chip_o;
  logic [DW-1:0]     best_dopp_o;
  logic [MAG_W-1:0]  best_mag_o;
  logic              corr_start_o;
  logic [4:0]        corr_sv_o;
  logic [9:0]        corr_chip_o;
  logic [DW-1:0]     corr_dopp_o;
  logic              corr_done_i = 1'b0;
  logic signed [15:0] corr_i_i = '0;
  logic signed [15:0] corr_q_i = '0;

  l1ca_acq_ctrl #(.NUM_DOPP(ND)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .sv_i         (sv_i),
    .thresh_i     (thresh_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .found_o      (found_o),
    .best_chip_o  (best_chip_o),
    .best_dopp_o  (best_dopp_o),
    .best_mag_o   (best_mag_o),
    .corr_start_o (corr_start_o),
    .corr_sv_o    (corr_sv_o),
    .corr_chip_o  (corr_chip_o),
    .corr_dopp_o  (corr_dopp_o),
    .corr_done_i  (corr_done_i),
    .corr_i_i     (corr_i_i),
    .corr_q_i     (corr_q_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Correlator model: fixed latency, zero response except listed cells
  int lat = 3;
  int cnt = 0;
  int sp_n = 0;
  int sp_d [2];
  int sp_c [2];
  int sp_iv[2];
  int sp_qv[2];
  logic [9:0]    c_chip;
  logic [DW-1:0] c_dopp;

  always @(negedge clk) begin
    if (corr_start_o === 1'b1) begin
      cnt = lat;
      c_chip = corr_chip_o;
      c_dopp = corr_dopp_o;
      corr_done_i = 1'b0;
    end else if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        corr_done_i = 1'b1;
        corr_i_i = '0;
        corr_q_i = '0;
        for (int k = 0; k < sp_n; k++) begin
          if (int'(c_dopp) == sp_d[k] && int'(c_chip) == sp_c[k]) begin
            corr_i_i = 16'(sp_iv[k]);
            corr_q_i = 16'(sp_qv[k]);
          end
        end
      end else begin
        corr_done_i = 1'b0;
      end
    end else begin
      corr_done_i = 1'b0;
    end
  end

  // Request monitor: counts pulses, logs issue order, checks sweep order
  int n_issue = 0;
  int n_done = 0;
  int order_err = 0;
  logic [9:0]    log_chip [0:NCELL-1];
  logic [DW-1:0] log_dopp [0:NCELL-1];

  always @(posedge clk) begin
    if (corr_start_o === 1'b1) begin
      if (n_issue < NCELL) begin
        if (corr_chip_o !== 10'(n_issue % 1023) || corr_dopp_o !== DW'(n_issue / 1023))
          order_err = order_err + 1;
        log_chip[n_issue] = corr_chip_o;
        log_dopp[n_issue] = corr_dopp_o;
      end
      n_issue = n_issue + 1;
    end
    if (done_o === 1'b1) n_done = n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [MAG_W-1:0] thr, input logic [4:0] sv);
    @(negedge clk);
    n_issue = 0;
    n_done = 0;
    order_err = 0;
    start_i = 1'b1;
    sv_i = sv;
    thresh_i = thr;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge clk);
      if (done_o === 1'b1) seen = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic chk_result(input string tag, input int f, input int c, input int d, input int m);
    chk({tag, "_found"}, 32'(found_o), f);
    chk({tag, "_best_chip"}, 32'(best_chip_o), c);
    chk({tag, "_best_dopp"}, 32'(best_dopp_o), d);
    chk({tag, "_best_mag"}, 32'(best_mag_o), m);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done_o), 0);
    chk({tag, "_idle_after"}, 32'(busy_o), 0);
    @(negedge clk);
    chk({tag, "_pulses"}, n_issue, NCELL);
    chk({tag, "_done_count"}, n_done, 1);
    chk({tag, "_order"}, order_err, 0);
  endtask

  initial begin
    int found_abort;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_found", 32'(found_o), 0);
    chk("rst_best_mag", 32'(best_mag_o), 0);
    chk("rst_corr_start", 32'(corr_start_o), 0);
    chk("rst_corr_chip", 32'(corr_chip_o), 0);
    nrst = 1'b1;

    // Single peak, with a start pulse while busy that must be ignored
    lat = 3;
    sp_n = 1;
    sp_d[0] = 2; sp_c[0] = 517; sp_iv[0] = -300; sp_qv[0] = 200;
    do_start(17'd400, 5'd7);
    chk("pk_busy", 32'(busy_o), 1);
    chk("pk_corr_start", 32'(corr_start_o), 1);
    chk("pk_corr_sv", 32'(corr_sv_o), 7);
    repeat (200) @(negedge clk);
    start_i = 1'b1; sv_i = 5'd3; thresh_i = 17'd0;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_start_sv", 32'(corr_sv_o), 7);
    wait_done("pk");
    chk_result("pk", 1, 517, 2, 500);

    // Reset mid-WAIT: everything back to zero immediately
    do_start(17'd400, 5'd9);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy_o), 0);
    chk("mrst_found", 32'(found_o), 0);
    chk("mrst_best_chip", 32'(best_chip_o), 0);
    chk("mrst_best_dopp", 32'(best_dopp_o), 0);
    chk("mrst_corr_sv", 32'(corr_sv_o), 0);
    @(negedge clk);
    nrst = 1'b1;
    n_issue = 0;
    repeat (10) @(negedge clk);
    chk("mrst_no_issue", n_issue, 0);

    // Reset during ISSUE drops the request without a clock edge
    do_start(17'd400, 5'd9);
    chk("arst_pre", 32'(corr_start_o), 1);
    nrst = 1'b0;
    #1;
    chk("arst_corr_start", 32'(corr_start_o), 0);
    @(negedge clk);
    nrst = 1'b1;

    // Same peak, threshold just above it
    do_start(17'd501, 5'd7);
    wait_done("thr");
    chk_result("thr", 0, 517, 2, 500);

    // Equal peaks: first in search order wins; chip wrap into next bin
    lat = 1;
    sp_n = 2;
    sp_d[0] = 0; sp_c[0] = 5; sp_iv[0] = 500; sp_qv[0] = 0;
    sp_d[1] = 1; sp_c[1] = 3; sp_iv[1] = 0;   sp_qv[1] = -500;
    do_start(17'd0, 5'd1);
    wait_done("tie");
    chk_result("tie", 1, 5, 0, 500);
    chk("seq_chip_1021", 32'(log_chip[1021]), 1021);
    chk("seq_chip_1022", 32'(log_chip[1022]), 1022);
    chk("seq_dopp_1022", 32'(log_dopp[1022]), 0);
    chk("seq_chip_wrap", 32'(log_chip[1023]), 0);
    chk("seq_dopp_wrap", 32'(log_dopp[1023]), 1);

    // Most negative I and Q
    sp_n = 1;
    sp_d[0] = 1; sp_c[0] = 0; sp_iv[0] = -32768; sp_qv[0] = -32768;
    do_start(17'd65536, 5'd2);
    wait_done("ext");
    chk_result("ext", 1, 0, 1, 65536);

    // All-zero responses with zero threshold
    sp_n = 0;
    do_start(17'd0, 5'd2);
    wait_done("zero");
    chk_result("zero", 1, 0, 0, 0);

    // Abort in cell 100; the late corr_done_i must be ignored
    lat = 3;
    do_start(17'd131071, 5'd4);
    found_abort = 0;
    for (int k = 0; k < 2000 && found_abort == 0; k++) begin
      @(negedge clk);
      if (corr_start_o === 1'b1 && corr_chip_o == 10'd100 && corr_dopp_o == '0) found_abort = 1;
    end
    chk("abort_reached", found_abort, 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_idle", 32'(busy_o), 0);
    chk("abort_pulses", n_issue, 101);
    repeat (10) @(negedge clk);
    chk("abort_late_idle", 32'(busy_o), 0);
    chk("abort_late_pulses", n_issue, 101);
    chk("abort_no_done", n_done, 0);
    chk("abort_found_held", 32'(found_o), 1);

    // Start and abort together in IDLE
    @(negedge clk);
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    chk("sa_busy", 32'(busy_o), 0);
    repeat (5) @(negedge clk);
    chk("sa_pulses", n_issue, 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
